// File: rtl/mem_handshake_ram.sv
// Byte-addressed big-endian RAM with MOV/MOC handshake, programmable wait states,
// byte/halfword/word accesses with sign/zero extension, and an access-error flag.
module mem_handshake_ram #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MOV,
  input  logic                  RW,
  input  logic [1:0]            SIZE,
  input  logic                  SE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [31:0]           DIN,
  output logic [31:0]           DOUT,
  output logic                  MOC,
  output logic                  ERR
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            size_q, size_d;
  logic                  se_q, se_d;
  logic [31:0]           din_q, din_d;
  logic [31:0]           dout_q, dout_d;
  logic                  moc_q, moc_d;
  logic                  err_q, err_d;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] hi_bits;
  logic [AW-1:0]         a0, a1, a2, a3;
  logic                  acc_err;
  logic                  wr_en;
  logic [31:0]           rdata;

  // Byte lanes derived from the aligned base; misaligned cases are flagged as errors
  // before these indices are ever used for a real access.
  assign a0      = addr_q[AW-1:0];
  assign a1      = {a0[AW-1:1], 1'b1};
  assign a2      = {a0[AW-1:2], 2'b10};
  assign a3      = {a0[AW-1:2], 2'b11};
  assign hi_bits = addr_q >> AW;

  assign acc_err = (size_q == 2'b11)
                 | ((size_q == 2'b01) & addr_q[0])
                 | ((size_q == 2'b10) & (|addr_q[1:0]))
                 | (|hi_bits);

  always_comb begin
    rdata = '0;
    case (size_q)
      2'b00:   rdata = {{24{se_q & mem[a0][7]}}, mem[a0]};
      2'b01:   rdata = {{16{se_q & mem[a0][7]}}, mem[a0], mem[a1]};
      default: rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    se_d    = se_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MOV) begin
          addr_d  = ADDR;
          rw_d    = RW;
          size_d  = SIZE;
          se_d    = SE;
          din_d   = DIN;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!MOV) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          state_d = S_DONE;
          if (acc_err) begin
            err_d  = 1'b1;
            dout_d = '0;
          end else if (rw_q) begin
            dout_d = rdata;
          end else begin
            dout_d = '0;
            wr_en  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!MOV) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      se_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; wr_en is only raised from BUSY, which reset forces away.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (size_q)
        2'b00: mem[a0] <= din_q[7:0];
        2'b01: begin
          mem[a0] <= din_q[15:8];
          mem[a1] <= din_q[7:0];
        end
        2'b10: begin
          mem[a0] <= din_q[31:24];
          mem[a1] <= din_q[23:16];
          mem[a2] <= din_q[15:8];
          mem[a3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign DOUT = dout_q;
  assign MOC  = moc_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Bench for mem_handshake_ram: two instances (2 and 0 wait states), a directed
// vector table, hand-written handshake/abort/reset sequences and a random run.
module tb_mem_handshake_ram;

  localparam int unsigned DEPTH = 512;

  logic        clk;
  logic        reset;
  logic        mov  [2];
  logic        rw   [2];
  logic [1:0]  size [2];
  logic        se   [2];
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        moc  [2];
  logic        err  [2];

  int vectors;
  int miscompares;

  logic [7:0] mdl [2][DEPTH];

  mem_handshake_ram #(.DEPTH(DEPTH), .WAIT_STATES(2), .ADDR_WIDTH(32)) dut_ws2 (
    .clk(clk), .reset(reset), .MOV(mov[0]), .RW(rw[0]), .SIZE(size[0]), .SE(se[0]),
    .ADDR(addr[0]), .DIN(din[0]), .DOUT(dout[0]), .MOC(moc[0]), .ERR(err[0])
  );

  mem_handshake_ram #(.DEPTH(DEPTH), .WAIT_STATES(0), .ADDR_WIDTH(32)) dut_ws0 (
    .clk(clk), .reset(reset), .MOV(mov[1]), .RW(rw[1]), .SIZE(size[1]), .SE(se[1]),
    .ADDR(addr[1]), .DIN(din[1]), .DOUT(dout[1]), .MOC(moc[1]), .ERR(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain byte array, big-endian assembly, extension by arithmetic.
  function automatic void model_access(input int inst, input logic r, input logic [1:0] sz,
                                       input logic s, input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] exp_d, output logic exp_e);
    int unsigned n;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_e = (sz == 2'd3) || ((a % n) != 0) || ((longint'(a) + longint'(n)) > longint'(DEPTH));
    exp_d = '0;
    if (!exp_e) begin
      if (r) begin
        for (int i = 0; i < int'(n); i++) exp_d = (exp_d << 8) | 32'(mdl[inst][a + i]);
        if (s && n < 4 && exp_d[8*n-1]) exp_d = exp_d | (32'hFFFF_FFFF << (8*n));
      end else begin
        for (int i = 0; i < int'(n); i++) mdl[inst][a + i] = 8'(d >> (8*(int'(n)-1-i)));
      end
    end
  endfunction

  // One complete handshake; inputs are scrambled while waiting to show they are latched.
  task automatic run_vec(input int inst, input logic r, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e, input string nm);
    int lat;
    int ws;
    ws  = (inst == 0) ? 2 : 0;
    lat = 0;
    @(negedge clk);
    rw[inst] = r; size[inst] = sz; se[inst] = s; addr[inst] = a; din[inst] = d;
    mov[inst] = 1'b1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (moc[inst]) break;
      addr[inst] = $urandom; din[inst] = $urandom;
      rw[inst] = 1'($urandom_range(0, 1)); size[inst] = 2'($urandom_range(0, 3));
    end
    check({nm, " latency"}, 32'(lat), 32'(ws + 2));
    check({nm, " dout"}, dout[inst], exp_d);
    check({nm, " err"}, 32'(err[inst]), 32'(exp_e));
    mov[inst] = 1'b0;
    @(negedge clk);
    check({nm, " moc_drop"}, 32'(moc[inst]), 32'd0);
    check({nm, " err_drop"}, 32'(err[inst]), 32'd0);
    check({nm, " dout_keep"}, dout[inst], exp_d);
  endtask

  typedef struct {
    logic        r;
    logic [1:0]  sz;
    logic        s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [31:0] ed;
    logic        ee;
    logic [31:0] held;
    logic [31:0] ra;
    int          pick;
    vectors = 0;
    miscompares = 0;

    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'hA1B2C3D4, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h10,       32'h0,        32'h000000A1, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,       32'h0,        32'h000000D4, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b1, 32'h13,       32'h0,        32'hFFFFFFD4, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h11,       32'h00000013, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b1, 32'h10,       32'h0,        32'hFFFFA113, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'h0,        32'hA113C3D4, 1'b0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h12,       32'hDEADBEEF, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h200,      32'hDEADBEEF, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'h0,        32'hA113C3D4, 1'b0};
    tbl[10] = '{1'b1, 2'd3, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b1, 2'd1, 1'b0, 32'h11,       32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h12,       32'h0,        32'h0000C3D4, 1'b0};
    tbl[13] = '{1'b1, 2'd1, 1'b1, 32'h12,       32'h0,        32'hFFFFC3D4, 1'b0};
    tbl[14] = '{1'b1, 2'd2, 1'b0, 32'h80000010, 32'h0,        32'h0,        1'b1};
    tbl[15] = '{1'b1, 2'd0, 1'b1, 32'h11,       32'h0,        32'h00000013, 1'b0};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h10,       32'h0,        32'h0000A113, 1'b0};

    for (int i = 0; i < 2; i++) begin
      mov[i] = 1'b0; rw[i] = 1'b0; size[i] = '0; se[i] = 1'b0; addr[i] = '0; din[i] = '0;
    end

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset moc", 32'(moc[i]), 32'd0);
      check("reset err", 32'(err[i]), 32'd0);
      check("reset dout", dout[i], 32'd0);
    end

    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 64; a += 4) begin
        ra = $urandom;
        model_access(i, 1'b0, 2'd2, 1'b0, 32'(a), ra, ed, ee);
        run_vec(i, 1'b0, 2'd2, 1'b0, 32'(a), ra, ed, ee, "preload");
      end
    end

    for (int i = 0; i < 17; i++) begin
      model_access(0, tbl[i].r, tbl[i].sz, tbl[i].s, tbl[i].a, tbl[i].d, ed, ee);
      run_vec(0, tbl[i].r, tbl[i].sz, tbl[i].s, tbl[i].a, tbl[i].d,
              tbl[i].exp_d, tbl[i].exp_e, $sformatf("table[%0d]", i));
    end

    // Abort: MOV dropped one cycle into a write must leave memory untouched.
    @(negedge clk);
    rw[0] = 1'b0; size[0] = 2'd2; se[0] = 1'b0; addr[0] = 32'h20; din[0] = 32'hFFFFFFFF;
    mov[0] = 1'b1;
    @(negedge clk);
    mov[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort moc", 32'(moc[0]), 32'd0);
    end
    model_access(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, ed, ee);
    run_vec(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, ed, ee, "abort readback");

    // Reset during BUSY: no write may land.
    @(negedge clk);
    rw[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h24; din[0] = 32'h11223344;
    mov[0] = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("busy reset moc", 32'(moc[0]), 32'd0);
    @(negedge clk);
    mov[0] = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("busy reset moc later", 32'(moc[0]), 32'd0);
    model_access(0, 1'b1, 2'd2, 1'b0, 32'h24, 32'h0, ed, ee);
    run_vec(0, 1'b1, 2'd2, 1'b0, 32'h24, 32'h0, ed, ee, "reset readback");

    // Zero wait states: hold in DONE, drop, then back-to-back request.
    model_access(1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0, ed, ee);
    @(negedge clk);
    rw[1] = 1'b1; size[1] = 2'd2; se[1] = 1'b0; addr[1] = 32'h8;
    mov[1] = 1'b1;
    @(negedge clk);
    check("ws0 accept moc", 32'(moc[1]), 32'd0);
    @(negedge clk);
    check("ws0 done moc", 32'(moc[1]), 32'd1);
    check("ws0 done dout", dout[1], ed);
    held = ed;
    for (int i = 0; i < 5; i++) begin
      addr[1] = $urandom;
      @(negedge clk);
      check("ws0 hold moc", 32'(moc[1]), 32'd1);
      check("ws0 hold dout", dout[1], held);
    end
    mov[1] = 1'b0;
    @(negedge clk);
    check("ws0 drop moc", 32'(moc[1]), 32'd0);
    model_access(1, 1'b1, 2'd0, 1'b1, 32'hB, 32'h0, ed, ee);
    rw[1] = 1'b1; size[1] = 2'd0; se[1] = 1'b1; addr[1] = 32'hB;
    mov[1] = 1'b1;
    @(negedge clk);
    check("b2b accept moc", 32'(moc[1]), 32'd0);
    @(negedge clk);
    check("b2b done moc", 32'(moc[1]), 32'd1);
    check("b2b dout", dout[1], ed);

    // Asynchronous reset while in DONE clears outputs without a clock edge.
    #1 reset = 1'b0;
    #1;
    check("async reset moc", 32'(moc[1]), 32'd0);
    check("async reset dout", dout[1], 32'd0);
    check("async reset err", 32'(err[1]), 32'd0);
    @(negedge clk);
    mov[1] = 1'b0;
    reset = 1'b1;

    for (int n = 0; n < 210; n++) begin
      int          inst;
      logic        r;
      logic [1:0]  sz;
      logic        s;
      logic [31:0] a;
      logic [31:0] d;
      inst = (n < 150) ? 1 : 0;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      a = 32'h200 + 32'($urandom_range(0, 255));
      else if (pick == 1) a = $urandom | 32'h8000_0000;
      else                a = 32'($urandom_range(0, 63));
      r  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      s  = 1'($urandom_range(0, 1));
      d  = $urandom;
      model_access(inst, r, sz, s, a, d, ed, ee);
      run_vec(inst, r, sz, s, a, d, ed, ee, $sformatf("random[%0d]", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
